// File: rtl/srl_delay_pkg.sv
// -----------------------------------------------------------------------------
// srl_delay_pkg
// Shared sizing constants for the 64-bit programmable shift-register delay
// line: total depth, width and count of the 16-bit cascade stages, and the
// widths of the delay-select and fill counter.
// Build option: SRL_DELAY_NEGCLK_EN (see srl_delay_line.sv) -- no effect here.
// -----------------------------------------------------------------------------
package srl_delay_pkg;

    localparam int DEPTH   = 64;   // total storage bits
    localparam int STAGE_W = 16;   // bits per cascade stage
    localparam int NSTAGES = 4;    // DEPTH / STAGE_W
    localparam int DLY_W   = 6;    // delay-select width, log2(DEPTH)

    localparam int ADDR_W  = 4;    // tap address inside one stage
    localparam int SEL_W   = 2;    // stage select, DLY[5:4]
    localparam int FILL_W  = 7;    // fill counter must represent 0..64

    // Fill saturates here: every tap holds a real bit once 64 have entered.
    localparam logic [FILL_W-1:0] FILL_MAX = 7'd64;

endpackage

// File: rtl/srl16_stage.sv
// -----------------------------------------------------------------------------
// srl16_stage
// One 16-bit shift stage of the delay line. Shifts d into bit 0 on each
// enabled edge, exposes an addressable tap and the oldest bit as a carry for
// the next stage in the cascade.
// Build option: SRL_DELAY_NEGCLK_EN -> state updates on the falling CLK edge.
//
// Ports
//   clk    in   sampling clock
//   rst    in   asynchronous active-high reset, loads INIT
//   ce     in   shift enable
//   d      in   serial data in (bit 0 is newest)
//   addr   in   4-bit tap address
//   q      out  data[addr], combinational
//   carry  out  data[15], combinational cascade output
// -----------------------------------------------------------------------------
module srl16_stage
    import srl_delay_pkg::*;
#(
    parameter logic [STAGE_W-1:0] INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              d,
    input  logic [ADDR_W-1:0] addr,
    output logic              q,
    output logic              carry
);

    logic [STAGE_W-1:0] data_q;
    logic [STAGE_W-1:0] data_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        data_d = data_q;
        if (ce) begin
            data_d = {data_q[STAGE_W-2:0], d};
        end
    end

    // NOTE: the storage is deliberately reset (to INIT) rather than left as
    // an unreset memory, because the reset contents are visible on the taps.
`ifdef SRL_DELAY_NEGCLK_EN
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) begin
            data_q <= INIT;
        end else begin
            data_q <= data_d;
        end
    end

    assign q     = data_q[addr];
    assign carry = data_q[STAGE_W-1];

endmodule

// File: rtl/srl_delay_line.sv
// -----------------------------------------------------------------------------
// srl_delay_line
// 64-bit programmable serial delay line built from four cascaded 16-bit
// stages. Q is the bit shifted in DLY_Q+1 enabled edges ago; VALID says that
// bit really came from D since reset rather than from INIT.
// Build option: SRL_DELAY_NEGCLK_EN -> all state updates on the falling CLK
// edge; default build uses the rising edge. Reset is identical in both.
//
// Ports
//   CLK     in   sampling clock (only clock)
//   RST     in   asynchronous active-high reset
//   CE      in   shift enable
//   D       in   serial data in
//   DLY_WE  in   delay-select write strobe
//   DLY     in   new delay select (delay = DLY+1 enabled shifts)
//   Q       out  data[dly_reg], combinational
//   Q63     out  data[63], cascade output
//   VALID   out  fill > dly_reg
//   DLY_Q   out  current delay select
// -----------------------------------------------------------------------------
module srl_delay_line
    import srl_delay_pkg::*;
#(
    parameter logic [DEPTH-1:0] INIT    = 64'h0,
    parameter logic [DLY_W-1:0] DLY_RST = 6'd15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             D,
    input  logic             DLY_WE,
    input  logic [DLY_W-1:0] DLY,
    output logic             Q,
    output logic             Q63,
    output logic             VALID,
    output logic [DLY_W-1:0] DLY_Q
);

    logic [DLY_W-1:0]  dly_sel_q, dly_sel_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    logic [NSTAGES-1:0] stage_din;
    logic [NSTAGES-1:0] stage_tap;
    logic [NSTAGES-1:0] stage_carry;

    // Stage 0 takes D; each later stage takes the previous stage's oldest bit.
    assign stage_din = {stage_carry[NSTAGES-2:0], D};

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        srl16_stage #(
            .INIT (INIT[i*STAGE_W +: STAGE_W])
        ) u_stage (
            .clk   (CLK),
            .rst   (RST),
            .ce    (CE),
            .d     (stage_din[i]),
            .addr  (dly_sel_q[ADDR_W-1:0]),
            .q     (stage_tap[i]),
            .carry (stage_carry[i])
        );
    end

    always_comb begin
        dly_sel_d = dly_sel_q;
        fill_d    = fill_q;
        if (DLY_WE) begin
            dly_sel_d = DLY;
        end
        // Saturate rather than wrap: once full, every tap is genuine data.
        if (CE && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + 7'd1;
        end
    end

`ifdef SRL_DELAY_NEGCLK_EN
    always_ff @(negedge CLK or posedge RST) begin
`else
    always_ff @(posedge CLK or posedge RST) begin
`endif
        if (RST) begin
            dly_sel_q <= DLY_RST;
            fill_q    <= '0;
        end else begin
            dly_sel_q <= dly_sel_d;
            fill_q    <= fill_d;
        end
    end

    // Tap selection uses the registered select, so a write on the same edge
    // as a shift points at the post-shift data.
    assign Q     = stage_tap[dly_sel_q[DLY_W-1 -: SEL_W]];
    assign Q63   = stage_carry[NSTAGES-1];
    assign VALID = (fill_q > {1'b0, dly_sel_q});
    assign DLY_Q = dly_sel_q;

endmodule

// File: tb/tb_srl_delay_line.sv
// -----------------------------------------------------------------------------
// tb_srl_delay_line
// Directed self-checking bench for srl_delay_line. Two instances share all
// inputs: u_init carries a non-zero INIT / DLY_RST=0 and is checked at resets;
// u_dut uses the default parameters and is checked for function.
// Inputs change and outputs are sampled 1 time unit after the active edge.
// -----------------------------------------------------------------------------
module tb_srl_delay_line;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       d;
    logic       dly_we;
    logic [5:0] dly;

    logic       a_q, a_q63, a_valid;
    logic [5:0] a_dly_q;
    logic       b_q, b_q63, b_valid;
    logic [5:0] b_dly_q;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [63:0] PAT = 64'hA5C3_96F0_1E2D_7B48;

    srl_delay_line #(
        .INIT    (64'h8000_0000_0000_0001),
        .DLY_RST (6'd0)
    ) u_init (
        .CLK (clk), .RST (rst), .CE (ce), .D (d), .DLY_WE (dly_we), .DLY (dly),
        .Q (a_q), .Q63 (a_q63), .VALID (a_valid), .DLY_Q (a_dly_q)
    );

    srl_delay_line u_dut (
        .CLK (clk), .RST (rst), .CE (ce), .D (d), .DLY_WE (dly_we), .DLY (dly),
        .Q (b_q), .Q63 (b_q63), .VALID (b_valid), .DLY_Q (b_dly_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit past the next active edge of the build.
    task automatic tick();
`ifdef SRL_DELAY_NEGCLK_EN
        @(negedge clk);
`else
        @(posedge clk);
`endif
        #1;
    endtask

    // Assert reset between edges, check reset outputs immediately, hold it
    // across an edge with CE/DLY_WE active, then release between edges.
    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check("rst_a_q",     a_q,     1);
        check("rst_a_q63",   a_q63,   1);
        check("rst_a_valid", a_valid, 0);
        check("rst_a_dly",   a_dly_q, 0);
        check("rst_b_dly",   b_dly_q, 15);
        check("rst_b_valid", b_valid, 0);
        check("rst_b_q63",   b_q63,   0);
        ce = 1'b1; d = 1'b1; dly_we = 1'b1; dly = 6'd33;
        tick();
        check("rst_ign_dly",   b_dly_q, 15);
        check("rst_ign_valid", b_valid, 0);
        check("rst_ign_q",     b_q,     0);
        rst = 1'b0; ce = 1'b0; d = 1'b0; dly_we = 1'b0; dly = 6'd0;
    endtask

    task automatic write_dly(input logic [5:0] v);
        ce = 1'b0; dly_we = 1'b1; dly = v;
        tick();
        dly_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; d = 1'b0; dly_we = 1'b0; dly = 6'd0;

        // Reset state with no clock edge yet.
        #2;
        check("por_a_q",     a_q,     1);
        check("por_a_q63",   a_q63,   1);
        check("por_a_valid", a_valid, 0);
        check("por_a_dly",   a_dly_q, 0);
        check("por_b_dly",   b_dly_q, 15);
        check("por_b_q",     b_q,     0);
        #1 rst = 1'b0;

        // Single pulse through DLY=4: Q high on enabled edge 5 only.
        write_dly(6'd4);
        check("d4_dly",   b_dly_q, 4);
        check("d4_q0",    b_q,     0);
        check("d4_valid0", b_valid, 0);
        for (int k = 1; k <= 8; k++) begin
            ce = 1'b1; d = (k == 1);
            tick();
            check($sformatf("d4_q_e%0d", k),     b_q,     (k == 5));
            check($sformatf("d4_valid_e%0d", k), b_valid, (k >= 5));
        end
        d = 1'b0;

        // CE toggling with DLY=2: only enabled edges advance the pulse.
        write_dly(6'd2);
        check("ce_valid_pre", b_valid, 1);
        begin
            logic [6:0] ce_seq;
            logic [6:0] q_exp;
            ce_seq = 7'b1010101;   // bit k: CE for step k (step 0 first)
            q_exp  = 7'b0110000;   // bit k: expected Q after step k
            for (int k = 0; k < 7; k++) begin
                ce = ce_seq[k]; d = (k == 0);
                tick();
                check($sformatf("ce_q_s%0d", k), b_q, q_exp[k]);
            end
        end
        ce = 1'b0; d = 1'b0;

        // Asynchronous reset mid-stream.
        ce = 1'b1; d = 1'b1;
        tick();
        check("pre_rst_valid", b_valid, 1);
        mid_reset();

        // 64-bit stream with DLY=63: Q/Q63 replay D 64 edges later.
        write_dly(6'd63);
        check("d63_valid0", b_valid, 0);
        for (int k = 1; k <= 64; k++) begin
            ce = 1'b1; d = PAT[k-1];
            tick();
            check($sformatf("d63_valid_e%0d", k), b_valid, (k == 64));
            check($sformatf("d63_q63_e%0d", k),   b_q63,   (k == 64) ? PAT[0] : 1'b0);
        end
        for (int j = 1; j < 64; j++) begin
            ce = 1'b1; d = 1'b0;
            tick();
            check($sformatf("d63_q63_r%0d", j), b_q63, PAT[j]);
            check($sformatf("d63_q_r%0d", j),   b_q,   PAT[j]);
        end
        // Saturated fill keeps VALID for every delay select.
        write_dly(6'd50);
        check("sat_valid_50", b_valid, 1);
        write_dly(6'd63);
        check("sat_valid_63", b_valid, 1);

        // Raise delay after fill=10 with a shift on the same edge.
        mid_reset();
        write_dly(6'd3);
        for (int k = 1; k <= 10; k++) begin
            ce = 1'b1; d = (k == 1);
            tick();
        end
        check("raise_valid_pre", b_valid, 1);
        ce = 1'b1; d = 1'b0; dly_we = 1'b1; dly = 6'd20;
        tick();
        dly_we = 1'b0;
        check("raise_dly",     b_dly_q, 20);
        check("raise_valid",   b_valid, 0);
        check("raise_q_post",  b_q,     0);
        for (int m = 1; m <= 10; m++) begin
            ce = 1'b1; d = 1'b0;
            tick();
            check($sformatf("raise_valid_m%0d", m), b_valid, (m == 10));
            check($sformatf("raise_q_m%0d", m),     b_q,     (m == 10));
        end
        // Lowering the select never drops VALID.
        write_dly(6'd0);
        check("lower_valid", b_valid, 1);

        ce = 1'b1; d = 1'b1;
        tick();
        mid_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
